// File: rtl/alu_arbiter.sv
// Shares one registered 32-bit ALU between two valid/ready requesters.
// One operation in flight; round-robin or fixed-priority arbitration.
module alu_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int DATA_W        = 32,
    parameter int FN_W          = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [FN_W-1:0]   req0_fn,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [FN_W-1:0]   req1_fn,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_data,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [FN_W-1:0]   fn_r;
    logic              owner_r;
    logic              last_grant_r;
    logic [DATA_W-1:0] resp0_data_r;
    logic [DATA_W-1:0] resp1_data_r;
    logic              resp0_valid_r;
    logic              resp1_valid_r;
    logic              busy_r;
    logic              grant0_s;
    logic              grant1_s;
    logic              req_hs_s;
    logic              resp_hs_s;
    logic [DATA_W-1:0] alu_out_s;

    // fn[5:4]: 00 compare, 01 arithmetic, 10 boolean, 11 shift; fn[3:0] picks the op.
    function automatic logic [DATA_W-1:0] alu_f(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [FN_W-1:0]   fn
    );
        logic [DATA_W-1:0] res;
        logic              bit_s;
        res   = {DATA_W{1'b0}};
        bit_s = 1'b0;
        case (fn[5:4])
            2'b00: begin
                case (fn[3:0])
                    4'b0000: bit_s = (a == b);
                    4'b0001: bit_s = ($signed(a) < $signed(b));
                    4'b0010: bit_s = (a < b);
                    4'b0011: bit_s = (a != b);
                    default: bit_s = 1'b0;
                endcase
                res = {{(DATA_W-1){1'b0}}, bit_s};
            end
            2'b01: begin
                case (fn[3:0])
                    4'b0000: res = a + b;
                    4'b0001: res = a - b;
                    default: res = a + b;
                endcase
            end
            2'b10: begin
                case (fn[3:0])
                    4'b0000: res = a & b;
                    4'b0001: res = a | b;
                    4'b0010: res = a ^ b;
                    4'b0011: res = ~(a | b);
                    default: res = a & b;
                endcase
            end
            2'b11: begin
                case (fn[3:0])
                    4'b0000: res = a << b[4:0];
                    4'b0001: res = a >> b[4:0];
                    4'b0010: res = $unsigned($signed(a) >>> b[4:0]);
                    default: res = a << b[4:0];
                endcase
            end
            default: res = {DATA_W{1'b0}};
        endcase
        return res;
    endfunction

    // Arbitration: a lone requester wins; on a tie, round-robin or port 0 by mode.
    always_comb begin
        grant1_s = 1'b0;
        if (req1_valid && !req0_valid) begin
            grant1_s = 1'b1;
        end else if (req1_valid && req0_valid && (PRIORITY_MODE == 0) && !last_grant_r) begin
            grant1_s = 1'b1;
        end else begin
            grant1_s = 1'b0;
        end
        grant0_s = req0_valid && !grant1_s;
    end

    // Ready is gated by reset so nothing is offered while rst_n is held low.
    assign req0_ready = rst_n && (state_r == ST_IDLE) && grant0_s;
    assign req1_ready = rst_n && (state_r == ST_IDLE) && grant1_s;
    assign req_hs_s   = (state_r == ST_IDLE) && (grant0_s || grant1_s);
    assign resp_hs_s  = owner_r ? (resp1_valid_r && resp1_ready)
                                : (resp0_valid_r && resp0_ready);
    assign alu_out_s  = alu_f(a_r, b_r, fn_r);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_hs_s) begin
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC: next_state_s = ST_DONE;
            ST_DONE: begin
                if (resp_hs_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Operand capture, result capture and response valid/busy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r           <= {DATA_W{1'b0}};
            b_r           <= {DATA_W{1'b0}};
            fn_r          <= {FN_W{1'b0}};
            owner_r       <= 1'b0;
            last_grant_r  <= 1'b1;
            resp0_data_r  <= {DATA_W{1'b0}};
            resp1_data_r  <= {DATA_W{1'b0}};
            resp0_valid_r <= 1'b0;
            resp1_valid_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            busy_r <= (next_state_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (req_hs_s) begin
                        a_r          <= grant1_s ? req1_a : req0_a;
                        b_r          <= grant1_s ? req1_b : req0_b;
                        fn_r         <= grant1_s ? req1_fn : req0_fn;
                        owner_r      <= grant1_s;
                        last_grant_r <= grant1_s;
                    end
                end
                ST_EXEC: begin
                    if (owner_r) begin
                        resp1_data_r  <= alu_out_s;
                        resp1_valid_r <= 1'b1;
                    end else begin
                        resp0_data_r  <= alu_out_s;
                        resp0_valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (resp_hs_s) begin
                        resp0_valid_r <= 1'b0;
                        resp1_valid_r <= 1'b0;
                    end
                end
                default: begin
                    resp0_valid_r <= 1'b0;
                    resp1_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign resp0_valid = resp0_valid_r;
    assign resp1_valid = resp1_valid_r;
    assign resp0_data  = resp0_data_r;
    assign resp1_data  = resp1_data_r;
    assign busy        = busy_r;

endmodule
